ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage of the RV32I core.
- Captures decoded instructions from decode with a valid/ready handshake and forwards results from MEM and WB.
- Detects load-use hazards.
- Presents final ALU operands (op_a/op_b) and control to the execute-stage ALU, including the set-less-than comparator.

Parameters:
- XLEN, 32, datapath width
- OPW, 4, ALU opcode width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  decode holds a valid instruction
- id_ready_o  out  1  stage accepts from decode this cycle
- id_pc_i  in  XLEN  instruction PC
- id_rs1_addr_i / id_rs2_addr_i  in  5  source register indices
- id_rs1_used_i / id_rs2_used_i  in  1  source actually read by instruction
- id_rs1_data_i / id_rs2_data_i  in  XLEN  regfile read data
- id_imm_i  in  XLEN  sign-extended immediate
- id_asel_i  in  1  0: op_a=rs1, 1: op_a=pc
- id_bsel_i  in  1  0: op_b=rs2, 1: op_b=imm
- id_alu_op_i  in  OPW  ALU operation
- id_rd_addr_i  in  5  destination register
- id_rd_wren_i  in  1  destination write enable
- flush_i  in  1  kill the held entry and the incoming one (branch/trap)
- ex_ready_i  in  1  execute stage consumes this cycle
- mem_rd_addr_i, mem_rd_wren_i, mem_rd_data_i, mem_is_load_i  in  5/1/XLEN/1  MEM-stage writer
- wb_rd_addr_i, wb_rd_wren_i, wb_rd_data_i  in  5/1/XLEN  WB-stage writer
- ex_valid_o  out  1  operands valid to ALU
- ex_op_a_o / ex_op_b_o  out  XLEN  final ALU operands
- ex_rs2_o  out  XLEN  forwarded rs2 (store data)
- ex_alu_op_o  out  OPW
- ex_pc_o  out  XLEN
- ex_rd_addr_o  out  5
- ex_rd_wren_o  out  1
- load_use_stall_o  out  1  hazard hold indicator

Behaviour:
- Reset (rst_ni=0, async):
  - Stage register valid (v_q) cleared.
  - All captured fields cleared to 0.
  - Outputs are therefore 0: ex_valid_o=0, load_use_stall_o=0, id_ready_o=1.
- Hazard: hz = v_q & mem_is_load_i & mem_rd_wren_i & (mem_rd_addr_i!=0) & ((rs1_used_q & rs1_addr_q==mem_rd_addr_i) | (rs2_used_q & rs2_addr_q==mem_rd_addr_i)).
- Stall output: load_use_stall_o = hz.
- Valid output: ex_valid_o = v_q & ~hz (combinational).
- Ready output: id_ready_o = flush_i | ~v_q | (ex_ready_i & ~hz).
- Capture on id_valid_i & id_ready_o & ~flush_i:
  - All id_* fields are registered.
  - v_q is set next cycle.
- Drain: v_q & ex_ready_i & ~hz with no capture -> v_q cleared next cycle.
- Hold: hz, or ~ex_ready_i -> register unchanged, ex_* stable.
- Flush:
  - flush_i has priority over capture and hold; v_q=0 next cycle and the incoming decode instruction is dropped.
  - The decode-side handshake still completes, because id_ready_o=1.
- Forwarding (combinational on registered sources), per source s in {rs1, rs2}:
  - addr_q==0 -> 0. x0 is never forwarded, regardless of the registered data.
  - Else mem_rd_wren_i & ~mem_is_load_i & mem_rd_addr_i==addr_q -> mem_rd_data_i. MEM has priority over WB.
  - Else wb_rd_wren_i & wb_rd_addr_i==addr_q -> wb_rd_data_i.
  - Else the registered regfile data.
- Held instructions re-evaluate forwarding every cycle.
  - Example: after a load-use stall clears, the load data arrives through WB.
- Operand select:
  - ex_op_a_o = asel_q ? pc_q : fwd_rs1.
  - ex_op_b_o = bsel_q ? imm_q : fwd_rs2.
  - ex_rs2_o = fwd_rs2 always.
- Pass-through: ex_alu_op_o, ex_pc_o, ex_rd_addr_o, ex_rd_wren_o are the registered values.
- Qualification: downstream ignores ex_rd_wren_o unless ex_valid_o.
- Latency: 1 cycle decode-to-ex_valid_o when unstalled; throughput 1/cycle.
- Simultaneous drain and capture: the new entry replaces the old in the same edge with no bubble.

Test Plan:
- Reset mid-operation: v_q=1, then rst_ni low for one cycle -> ex_valid_o=0 immediately, all ex_* = 0, id_ready_o=1.
- Back-to-back ALU forwarding (add x5 then slt x6,x5,x7):
  - Conditions: MEM writes x5=0xFFFF_FFF0 (non-load), WB writes x5=0x1, regfile x5=0.
  - Required: ex_op_a_o=0xFFFF_FFF0, i.e. MEM wins.
- Load-use:
  - Conditions: held rs2=x8 used, MEM load to x8.
  - Required: load_use_stall_o=1, ex_valid_o=0, id_ready_o=0.
  - Next cycle WB writes x8=0x7FFF_FFFF -> ex_op_b_o=0x7FFF_FFFF, ex_valid_o=1.
- x0 protection: rs1=x0 while MEM and WB both write x0 with 0xDEAD_BEEF -> ex_op_a_o=0.
- Backpressure: ex_ready_i=0 for 3 cycles with id_valid_i=1 -> id_ready_o=0 and ex_* stable; ex_ready_i=1 -> new entry loads next cycle with no bubble.
- Flush: flush_i=1 together with id_valid_i=1 and a held entry -> next cycle ex_valid_o=0; the dropped instruction never appears on ex_*.

Source files
------------

// File: rtl/ex_operand_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ex_operand_stage                                                           |
// | ID/EX pipeline register with MEM/WB operand forwarding and load-use hold.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [4:0]      id_rs1_addr_i,
  input  logic [4:0]      id_rs2_addr_i,
  input  logic            id_rs1_used_i,
  input  logic            id_rs2_used_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic            id_asel_i,
  input  logic            id_bsel_i,
  input  logic [OPW-1:0]  id_alu_op_i,
  input  logic [4:0]      id_rd_addr_i,
  input  logic            id_rd_wren_i,
  input  logic            flush_i,
  input  logic            ex_ready_i,
  input  logic [4:0]      mem_rd_addr_i,
  input  logic            mem_rd_wren_i,
  input  logic [XLEN-1:0] mem_rd_data_i,
  input  logic            mem_is_load_i,
  input  logic [4:0]      wb_rd_addr_i,
  input  logic            wb_rd_wren_i,
  input  logic [XLEN-1:0] wb_rd_data_i,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_op_a_o,
  output logic [XLEN-1:0] ex_op_b_o,
  output logic [XLEN-1:0] ex_rs2_o,
  output logic [OPW-1:0]  ex_alu_op_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [4:0]      ex_rd_addr_o,
  output logic            ex_rd_wren_o,
  output logic            load_use_stall_o
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [4:0]      r_rs1_addr;
  logic [4:0]      r_rs2_addr;
  logic            r_rs1_used;
  logic            r_rs2_used;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic            r_asel;
  logic            r_bsel;
  logic [OPW-1:0]  r_alu_op;
  logic [4:0]      r_rd_addr;
  logic            r_rd_wren;

  logic            w_hz;
  logic            w_capture;
  logic            w_drain;
  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;

  // A load in MEM cannot forward yet; hold until its data reaches WB.
  assign w_hz = r_valid & mem_is_load_i & mem_rd_wren_i & (mem_rd_addr_i != 5'd0) &
                ((r_rs1_used & (r_rs1_addr == mem_rd_addr_i)) |
                 (r_rs2_used & (r_rs2_addr == mem_rd_addr_i)));

  assign load_use_stall_o = w_hz;
  assign ex_valid_o       = r_valid & ~w_hz;
  assign id_ready_o       = flush_i | ~r_valid | (ex_ready_i & ~w_hz);
  assign w_capture        = id_valid_i & id_ready_o & ~flush_i;
  assign w_drain          = r_valid & ex_ready_i & ~w_hz;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rs1_used <= 1'b0;
      r_rs2_used <= 1'b0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_asel     <= 1'b0;
      r_bsel     <= 1'b0;
      r_alu_op   <= '0;
      r_rd_addr  <= '0;
      r_rd_wren  <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid    <= 1'b1;
      r_pc       <= id_pc_i;
      r_rs1_addr <= id_rs1_addr_i;
      r_rs2_addr <= id_rs2_addr_i;
      r_rs1_used <= id_rs1_used_i;
      r_rs2_used <= id_rs2_used_i;
      r_rs1_data <= id_rs1_data_i;
      r_rs2_data <= id_rs2_data_i;
      r_imm      <= id_imm_i;
      r_asel     <= id_asel_i;
      r_bsel     <= id_bsel_i;
      r_alu_op   <= id_alu_op_i;
      r_rd_addr  <= id_rd_addr_i;
      r_rd_wren  <= id_rd_wren_i;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  // x0 first, then MEM (youngest non-load result), then WB, then regfile.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0]      addr,
                                              input logic [XLEN-1:0] rf_data);
    if (addr == 5'd0)
      return '0;
    else if (mem_rd_wren_i & ~mem_is_load_i & (mem_rd_addr_i == addr))
      return mem_rd_data_i;
    else if (wb_rd_wren_i & (wb_rd_addr_i == addr))
      return wb_rd_data_i;
    else
      return rf_data;
  endfunction

  assign w_fwd_rs1 = fwd_sel(r_rs1_addr, r_rs1_data);
  assign w_fwd_rs2 = fwd_sel(r_rs2_addr, r_rs2_data);

  assign ex_op_a_o    = r_asel ? r_pc  : w_fwd_rs1;
  assign ex_op_b_o    = r_bsel ? r_imm : w_fwd_rs2;
  assign ex_rs2_o     = w_fwd_rs2;
  assign ex_alu_op_o  = r_alu_op;
  assign ex_pc_o      = r_pc;
  assign ex_rd_addr_o = r_rd_addr;
  assign ex_rd_wren_o = r_rd_wren;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ex_operand_stage                                                        |
// | Directed bench for the ID/EX operand stage; inputs change on negedge.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ex_operand_stage;

  localparam int XLEN = 32;
  localparam int OPW  = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            id_valid_i;
  logic            id_ready_o;
  logic [XLEN-1:0] id_pc_i;
  logic [4:0]      id_rs1_addr_i, id_rs2_addr_i;
  logic            id_rs1_used_i, id_rs2_used_i;
  logic [XLEN-1:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
  logic            id_asel_i, id_bsel_i;
  logic [OPW-1:0]  id_alu_op_i;
  logic [4:0]      id_rd_addr_i;
  logic            id_rd_wren_i;
  logic            flush_i, ex_ready_i;
  logic [4:0]      mem_rd_addr_i;
  logic            mem_rd_wren_i;
  logic [XLEN-1:0] mem_rd_data_i;
  logic            mem_is_load_i;
  logic [4:0]      wb_rd_addr_i;
  logic            wb_rd_wren_i;
  logic [XLEN-1:0] wb_rd_data_i;
  logic            ex_valid_o;
  logic [XLEN-1:0] ex_op_a_o, ex_op_b_o, ex_rs2_o, ex_pc_o;
  logic [OPW-1:0]  ex_alu_op_o;
  logic [4:0]      ex_rd_addr_o;
  logic            ex_rd_wren_o;
  logic            load_use_stall_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  ex_operand_stage #(.XLEN(XLEN), .OPW(OPW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_pc_i(id_pc_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_asel_i(id_asel_i), .id_bsel_i(id_bsel_i),
    .id_alu_op_i(id_alu_op_i), .id_rd_addr_i(id_rd_addr_i), .id_rd_wren_i(id_rd_wren_i),
    .flush_i(flush_i), .ex_ready_i(ex_ready_i),
    .mem_rd_addr_i(mem_rd_addr_i), .mem_rd_wren_i(mem_rd_wren_i),
    .mem_rd_data_i(mem_rd_data_i), .mem_is_load_i(mem_is_load_i),
    .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_wren_i(wb_rd_wren_i), .wb_rd_data_i(wb_rd_data_i),
    .ex_valid_o(ex_valid_o), .ex_op_a_o(ex_op_a_o), .ex_op_b_o(ex_op_b_o),
    .ex_rs2_o(ex_rs2_o), .ex_alu_op_o(ex_alu_op_o), .ex_pc_o(ex_pc_o),
    .ex_rd_addr_o(ex_rd_addr_o), .ex_rd_wren_o(ex_rd_wren_o),
    .load_use_stall_o(load_use_stall_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm, input logic asel,
                          input logic bsel, input logic [3:0] op, input logic [4:0] rd,
                          input logic wren);
    id_valid_i = 1'b1;  id_pc_i = pc;
    id_rs1_addr_i = rs1; id_rs2_addr_i = rs2; id_rs1_used_i = u1; id_rs2_used_i = u2;
    id_rs1_data_i = d1;  id_rs2_data_i = d2;  id_imm_i = imm;
    id_asel_i = asel;    id_bsel_i = bsel;    id_alu_op_i = op;
    id_rd_addr_i = rd;   id_rd_wren_i = wren;
  endtask

  task automatic clear_fwd();
    mem_rd_addr_i = 5'd0; mem_rd_wren_i = 1'b0; mem_rd_data_i = '0; mem_is_load_i = 1'b0;
    wb_rd_addr_i  = 5'd0; wb_rd_wren_i  = 1'b0; wb_rd_data_i  = '0;
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b1;
    drive_id('0, 5'd0, 5'd0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
    id_valid_i = 1'b0;
    clear_fwd();
    repeat (2) @(negedge clk_i);
    #1;
    check_val("rst_valid", 32'(ex_valid_o), 32'd0);
    check_val("rst_stall", 32'(load_use_stall_o), 32'd0);
    check_val("rst_ready", 32'(id_ready_o), 32'd1);
    check_val("rst_op_a", ex_op_a_o, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // slt x6,x5,x7 while MEM and WB both hold a value for x5
    @(negedge clk_i);
    drive_id(32'h100, 5'd5, 5'd7, 1'b1, 1'b1, 32'h0, 32'h22, 32'h0, 1'b0, 1'b0, 4'h3, 5'd6, 1'b1);
    ex_ready_i = 1'b0;
    @(negedge clk_i);
    id_valid_i = 1'b0;
    mem_rd_addr_i = 5'd5; mem_rd_wren_i = 1'b1; mem_rd_data_i = 32'hFFFF_FFF0; mem_is_load_i = 1'b0;
    wb_rd_addr_i  = 5'd5; wb_rd_wren_i  = 1'b1; wb_rd_data_i  = 32'h1;
    #1;
    check_val("fwd_valid", 32'(ex_valid_o), 32'd1);
    check_val("fwd_mem_wins", ex_op_a_o, 32'hFFFF_FFF0);
    check_val("fwd_op_b_rf", ex_op_b_o, 32'h22);
    check_val("fwd_alu_op", 32'(ex_alu_op_o), 32'h3);
    check_val("fwd_pc", ex_pc_o, 32'h100);
    check_val("fwd_rd", 32'(ex_rd_addr_o), 32'd6);
    mem_rd_wren_i = 1'b0;
    #1;
    check_val("fwd_wb_only", ex_op_a_o, 32'h1);
    wb_rd_wren_i = 1'b0;
    #1;
    check_val("fwd_regfile", ex_op_a_o, 32'h0);
    ex_ready_i = 1'b1;

    // load-use on rs2=x8, op_a taken from pc
    @(negedge clk_i);
    drive_id(32'h200, 5'd1, 5'd8, 1'b1, 1'b1, 32'h10, 32'h5, 32'h0, 1'b1, 1'b0, 4'h0, 5'd9, 1'b1);
    @(negedge clk_i);
    drive_id(32'h300, 5'd0, 5'd0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'h123, 1'b0, 1'b1, 4'h1, 5'd10, 1'b1);
    mem_rd_addr_i = 5'd8; mem_rd_wren_i = 1'b1; mem_rd_data_i = 32'h1234_5678; mem_is_load_i = 1'b1;
    #1;
    check_val("lu_stall", 32'(load_use_stall_o), 32'd1);
    check_val("lu_valid", 32'(ex_valid_o), 32'd0);
    check_val("lu_ready", 32'(id_ready_o), 32'd0);
    @(negedge clk_i);
    clear_fwd();
    wb_rd_addr_i = 5'd8; wb_rd_wren_i = 1'b1; wb_rd_data_i = 32'h7FFF_FFFF;
    #1;
    check_val("lu_clear_stall", 32'(load_use_stall_o), 32'd0);
    check_val("lu_clear_valid", 32'(ex_valid_o), 32'd1);
    check_val("lu_wb_op_b", ex_op_b_o, 32'h7FFF_FFFF);
    check_val("lu_op_a_pc", ex_op_a_o, 32'h200);
    check_val("lu_ready_again", 32'(id_ready_o), 32'd1);
    @(negedge clk_i);
    id_valid_i = 1'b0; ex_ready_i = 1'b0;
    clear_fwd();
    #1;
    check_val("nobubble_valid", 32'(ex_valid_o), 32'd1);
    check_val("nobubble_pc", ex_pc_o, 32'h300);
    check_val("imm_op_b", ex_op_b_o, 32'h123);

    // x0 protection on a held entry whose registered rs1 data is nonzero
    mem_rd_addr_i = 5'd0; mem_rd_wren_i = 1'b1; mem_rd_data_i = 32'hDEAD_BEEF; mem_is_load_i = 1'b0;
    wb_rd_addr_i  = 5'd0; wb_rd_wren_i  = 1'b1; wb_rd_data_i  = 32'hDEAD_BEEF;
    #1;
    check_val("x0_op_a", ex_op_a_o, 32'h0);
    check_val("x0_rs2", ex_rs2_o, 32'h0);
    mem_is_load_i = 1'b1;
    #1;
    check_val("x0_load_no_stall", 32'(load_use_stall_o), 32'd0);
    clear_fwd();

    // backpressure: three held cycles, then the new entry loads without a bubble
    @(negedge clk_i);
    drive_id(32'h400, 5'd2, 5'd3, 1'b1, 1'b1, 32'h44, 32'h55, 32'h0, 1'b0, 1'b0, 4'h2, 5'd11, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("bp_ready", 32'(id_ready_o), 32'd0);
      check_val("bp_pc_stable", ex_pc_o, 32'h300);
      check_val("bp_valid", 32'(ex_valid_o), 32'd1);
      @(negedge clk_i);
    end
    ex_ready_i = 1'b1;
    #1;
    check_val("bp_release_ready", 32'(id_ready_o), 32'd1);
    @(negedge clk_i);
    id_valid_i = 1'b0; ex_ready_i = 1'b0;
    #1;
    check_val("bp_new_pc", ex_pc_o, 32'h400);
    check_val("bp_new_valid", 32'(ex_valid_o), 32'd1);
    check_val("bp_new_op_a", ex_op_a_o, 32'h44);

    // flush with a held entry and an incoming instruction
    drive_id(32'h500, 5'd4, 5'd4, 1'b1, 1'b1, 32'h66, 32'h66, 32'h0, 1'b0, 1'b0, 4'h7, 5'd12, 1'b1);
    flush_i = 1'b1;
    #1;
    check_val("flush_ready", 32'(id_ready_o), 32'd1);
    @(negedge clk_i);
    flush_i = 1'b0; id_valid_i = 1'b0;
    #1;
    check_val("flush_valid", 32'(ex_valid_o), 32'd0);
    check_val("flush_dropped_pc", 32'(ex_pc_o == 32'h500), 32'd0);
    @(negedge clk_i);
    #1;
    check_val("flush_stays_empty", 32'(ex_valid_o), 32'd0);

    // reset while an entry is held
    drive_id(32'h600, 5'd9, 5'd0, 1'b1, 1'b0, 32'h77, 32'h0, 32'h55, 1'b0, 1'b1, 4'h5, 5'd3, 1'b1);
    @(negedge clk_i);
    id_valid_i = 1'b0;
    #1;
    check_val("pre_rst_valid", 32'(ex_valid_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    check_val("mid_rst_valid", 32'(ex_valid_o), 32'd0);
    check_val("mid_rst_pc", ex_pc_o, 32'h0);
    check_val("mid_rst_rd", 32'(ex_rd_addr_o), 32'd0);
    check_val("mid_rst_wren", 32'(ex_rd_wren_o), 32'd0);
    check_val("mid_rst_alu_op", 32'(ex_alu_op_o), 32'd0);
    check_val("mid_rst_op_a", ex_op_a_o, 32'h0);
    check_val("mid_rst_op_b", ex_op_b_o, 32'h0);
    check_val("mid_rst_ready", 32'(id_ready_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
